// File: rtl/ndn_spi_packet_assembler.sv
// SPI receive-side packet assembler for the NDN router FIB/PIT path.
// Collects metadata, prefix and optional payload bytes, then holds the packet for a valid/ready consumer.
module ndn_spi_packet_assembler #(
    parameter int PREFIX_BYTES = 8,
    parameter int DATA_BYTES   = 32,
    parameter int TYPE_BIT     = 6,
    parameter int TIMEOUT      = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      RX_valid,
    input  logic                      rx_byte_valid,
    input  logic [7:0]                data_SPI_to_FIB,
    output logic                      pkt_valid,
    input  logic                      pkt_ready,
    output logic                      pkt_is_interest,
    output logic [7:0]                pkt_metadata,
    output logic [8*PREFIX_BYTES-1:0] pkt_prefix,
    output logic [8*DATA_BYTES-1:0]   pkt_data,
    output logic                      rx_busy,
    output logic                      err_timeout,
    output logic                      err_restart,
    output logic                      err_overrun,
    output logic [7:0]                drop_count
);
    localparam int MAX_BYTES = (PREFIX_BYTES > DATA_BYTES) ? PREFIX_BYTES : DATA_BYTES;
    localparam int CW = $clog2(MAX_BYTES + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int PW = 8 * PREFIX_BYTES;
    localparam int DW = 8 * DATA_BYTES;
    localparam logic [CW-1:0] PREFIX_LAST = CW'(PREFIX_BYTES - 1);
    localparam logic [CW-1:0] DATA_LAST   = CW'(DATA_BYTES - 1);
    localparam logic [TW-1:0] IDLE_LIMIT  = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, META, PREFIX, DATA, HOLD} state_t;

    state_t        state, state_next;
    logic [CW-1:0] byte_cnt;
    logic [TW-1:0] idle_cnt;
    logic          assembling, start, restart, timeout, overrun, take_byte, last_byte;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        start      = 1'b0;
        restart    = 1'b0;
        timeout    = 1'b0;
        overrun    = 1'b0;
        take_byte  = 1'b0;
        last_byte  = 1'b0;
        assembling = (state == META) || (state == PREFIX) || (state == DATA);
        case (state)
            IDLE: begin
                if (RX_valid) begin
                    start      = 1'b1;
                    state_next = META;
                end
            end
            META, PREFIX, DATA: begin
                // A new start strobe wins over any byte presented in the same cycle.
                if (RX_valid) begin
                    restart    = 1'b1;
                    start      = 1'b1;
                    state_next = META;
                end else if (rx_byte_valid) begin
                    take_byte = 1'b1;
                    if (state == META) begin
                        state_next = PREFIX;
                    end else if (state == PREFIX && byte_cnt == PREFIX_LAST) begin
                        last_byte  = 1'b1;
                        state_next = pkt_metadata[TYPE_BIT] ? HOLD : DATA;
                    end else if (state == DATA && byte_cnt == DATA_LAST) begin
                        last_byte  = 1'b1;
                        state_next = HOLD;
                    end
                end else if (idle_cnt == IDLE_LIMIT) begin
                    timeout    = 1'b1;
                    state_next = IDLE;
                end
            end
            HOLD: begin
                if (pkt_ready) begin
                    start      = RX_valid;
                    state_next = RX_valid ? META : IDLE;
                end else if (RX_valid) begin
                    overrun = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pkt_metadata <= '0;
            pkt_prefix   <= '0;
            pkt_data     <= '0;
            byte_cnt     <= '0;
        end else if (start || timeout) begin
            pkt_metadata <= '0;
            pkt_prefix   <= '0;
            pkt_data     <= '0;
            byte_cnt     <= '0;
        end else if (take_byte) begin
            byte_cnt <= (last_byte || state == META) ? '0 : byte_cnt + CW'(1);
            case (state)
                META:    pkt_metadata <= data_SPI_to_FIB;
                PREFIX:  pkt_prefix   <= (pkt_prefix << 8) | PW'(data_SPI_to_FIB);
                DATA:    pkt_data     <= (pkt_data << 8) | DW'(data_SPI_to_FIB);
                default: ;
            endcase
        end
    end

    // The idle counter only runs while a packet is partially assembled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idle_cnt    <= '0;
            err_timeout <= 1'b0;
            err_restart <= 1'b0;
            err_overrun <= 1'b0;
            drop_count  <= '0;
        end else begin
            idle_cnt    <= (assembling && !RX_valid && !rx_byte_valid && !timeout) ?
                           idle_cnt + TW'(1) : '0;
            err_timeout <= timeout;
            err_restart <= restart;
            err_overrun <= overrun;
            if ((timeout || restart || overrun) && drop_count != 8'hFF)
                drop_count <= drop_count + 8'd1;
        end
    end

    assign pkt_valid       = (state == HOLD);
    assign rx_busy         = (state != IDLE);
    assign pkt_is_interest = pkt_metadata[TYPE_BIT];

endmodule
